commit_trace_buffer: RTL and testbench
======================================

COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 SHALL have parameters: DATA_W, default 16, data width; ADDR_W, default 16, memory address width; REG_W, default 4, register index width; DEPTH, default 16, record entries (power of 2, minimum 4); CNT_W, default 32, counter width.
REQ-002 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset.
REQ-003 SHALL have: en  in  1  capture enable; hlt  in  1  processor halt.
REQ-004 SHALL have: reg_we  in  1; reg_idx  in  REG_W; reg_data  in  DATA_W  register-write commit.
REQ-005 SHALL have: mem_re  in  1; mem_we  in  1; mem_addr  in  ADDR_W; mem_rdata  in  DATA_W; mem_wdata  in  DATA_W  memory access.
REQ-006 SHALL have: rec_valid  out  1; rec_ready  in  1; rec_kind  out  2; rec_idx  out  REG_W; rec_addr  out  ADDR_W; rec_data  out  DATA_W  record drain port.
REQ-007 SHALL have: inst_count  out  CNT_W; cycle_count  out  CNT_W; drop_count  out  CNT_W; fill  out  clog2(DEPTH)+1; overflow  out  1; halted  out  1.
REQ-008 Clock SHALL be clk; reset SHALL be rst_n, asynchronous, active-low; all state SHALL be clocked on the rising edge of clk.

Function
REQ-009 Active cycle: en=1 and halted=0; no records or counter changes outside active cycles.
REQ-010 Kinds: 0 REG, 1 LOAD, 2 STORE, 3 HALT.
REQ-011 Per active cycle, candidate records in fixed order: REG (reg_we), then memory (STORE if mem_we, else LOAD if mem_re; mem_we wins when both are set), then HALT (hlt); 0..3 records.
REQ-012 REG: idx=reg_idx, addr=0, data=reg_data; LOAD: idx=0, addr=mem_addr, data=mem_rdata; STORE: idx=0, addr=mem_addr, data=mem_wdata; HALT: idx=0, addr=0, data=low DATA_W bits of inst_count including this cycle's increment.
REQ-013 Atomic push: if free space (DEPTH minus fill at start of cycle, ignoring a same-cycle pop) is at least the candidate count, all candidates SHALL be written the same cycle; otherwise none is written, drop_count SHALL increase by the candidate count, and overflow SHALL set (sticky).
REQ-014 inst_count SHALL increment by 1 per active cycle with reg_we, mem_we or hlt set, whether or not records were dropped.
REQ-015 cycle_count SHALL increment by 1 per active cycle.
REQ-016 Drain: rec_valid = fill != 0; the head record SHALL be presented combinationally from storage; a pop occurs when rec_valid and rec_ready are both high.
REQ-017 A pop and pushes in the same cycle SHALL both take effect: fill_next = fill + pushed - popped.
REQ-018 Records SHALL drain in push order; read and write pointers SHALL wrap modulo DEPTH.
REQ-019 Halt: the first active cycle with hlt=1 SHALL set halted (sticky until reset), and capture SHALL freeze from the next cycle; draining SHALL continue while halted.
REQ-020 Counters SHALL wrap modulo 2^CNT_W.

Reset
REQ-021 While rst_n=0: fill=0, rec_valid=0, all counters 0, overflow=0, halted=0, pointers 0; rec_kind, rec_idx, rec_addr and rec_data SHALL be 0 when empty.
REQ-022 Reset asserted mid-operation SHALL discard all buffered records immediately, with no partial push.

Configuration
REQ-023 Macro TRACE_STAMP_EN defined: add output rec_stamp  out  CNT_W, holding cycle_count sampled before the increment of the push cycle and stored per record.
REQ-024 TRACE_STAMP_EN undefined: rec_stamp port and its storage SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-025 Shared package trace_pkg SHALL hold the rec_kind encoding and the record struct (kind, idx, addr, data, optional stamp).
REQ-026 Sub-module trace_fifo SHALL implement the 3-push/1-pop ring (pointers, fill, atomic space check); counters and record formation SHALL live in the top level.

Verification
REQ-027 Reset, then reg_we=1, reg_idx=3, reg_data=0x00A5 for one cycle -> one record REG/3/0x0000/0x00A5; inst_count=1; fill=1.
REQ-028 Same cycle reg_we (r1=0x1111), mem_we (addr 0x0040, wdata 0xBEEF) and hlt=1 -> three records REG, STORE, HALT(data=0x0001) in order; halted=1; later events are ignored.
REQ-029 DEPTH=4, rec_ready=0, four single REG cycles, then reg_we+mem_re -> fill=4, drop_count=2, overflow=1, inst_count=5.
REQ-030 fill=4, rec_ready=1, one REG push in the same cycle -> nothing is pushed (start-of-cycle fill check), drop_count increases by 1, and fill=3 after the pop.
REQ-031 Push and drain 37 records one per cycle with rec_ready=1 -> output order matches input order across pointer wrap; fill never exceeds 1.
REQ-032 With TRACE_STAMP_EN, en=0 for 5 cycles then one push at the third active cycle -> rec_stamp=2; and rst_n=0 pulsed with fill=3 -> fill=0 and rec_valid=0 immediately.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared definitions for the commit trace buffer.
// The record kind encoding and the canonical record layout live here.
// The record struct uses generous field widths so that any legal module
// parameterisation fits inside it. The top level narrows each field to
// its configured width before storage.
package trace_pkg;

    typedef enum logic [1:0] {
        KIND_REG   = 2'd0,
        KIND_LOAD  = 2'd1,
        KIND_STORE = 2'd2,
        KIND_HALT  = 2'd3
    } rec_kind_e;

    // Upper bounds on the configurable field widths.
    localparam int MAX_IDX_W   = 16;
    localparam int MAX_ADDR_W  = 64;
    localparam int MAX_DATA_W  = 64;
    localparam int MAX_STAMP_W = 64;

    // At most three records (REG, memory, HALT) are produced per cycle.
    localparam int MAX_PUSH = 3;

    typedef struct packed {
        rec_kind_e              kind;
        logic [MAX_IDX_W-1:0]   idx;
        logic [MAX_ADDR_W-1:0]  addr;
        logic [MAX_DATA_W-1:0]  data;
        logic [MAX_STAMP_W-1:0] stamp;
    } trace_rec_t;

    function automatic trace_rec_t rec_make(
        input rec_kind_e              kind,
        input logic [MAX_IDX_W-1:0]   idx,
        input logic [MAX_ADDR_W-1:0]  addr,
        input logic [MAX_DATA_W-1:0]  data,
        input logic [MAX_STAMP_W-1:0] stamp
    );
        trace_rec_t r;
        r.kind  = kind;
        r.idx   = idx;
        r.addr  = addr;
        r.data  = data;
        r.stamp = stamp;
        return r;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Ring buffer with up to three pushes and one pop per cycle.
// A push group is accepted only if all of it fits in the space free at the
// start of the cycle; a same-cycle pop does not make room for it.
// The head entry is read combinationally and forced to zero when empty.
module trace_fifo
    import trace_pkg::*;
#(
    parameter  int REC_W  = 38,
    parameter  int DEPTH  = 16,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int FILL_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        i_push_cnt,
    input  logic [REC_W-1:0]  i_push_data [MAX_PUSH],
    input  logic              i_pop,
    output logic              o_push_ok,
    output logic [REC_W-1:0]  o_head,
    output logic              o_valid,
    output logic [FILL_W-1:0] o_fill
);

    logic [REC_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [FILL_W-1:0] r_fill;

    logic [FILL_W-1:0] w_free;
    logic              w_push_ok;
    logic [1:0]        w_n_push;
    logic              w_pop;

    assign w_free    = FILL_W'(DEPTH) - r_fill;
    assign w_push_ok = (w_free >= FILL_W'(i_push_cnt));
    assign w_n_push  = w_push_ok ? i_push_cnt : 2'd0;
    assign w_pop     = i_pop && (r_fill != '0);

    // Pointer and occupancy update; pushes and a pop combine in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_n_push);
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
            r_fill   <= r_fill + FILL_W'(w_n_push) - FILL_W'(w_pop);
        end
    end

    // Storage write: accepted records land in consecutive slots.
    always_ff @(posedge clk) begin
        for (int k = 0; k < MAX_PUSH; k++) begin
            if (2'(k) < w_n_push) begin
                r_mem[r_wr_ptr + PTR_W'(k)] <= i_push_data[k];
            end
        end
    end

    assign o_push_ok = w_push_ok;
    assign o_valid   = (r_fill != '0);
    assign o_head    = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_fill    = r_fill;

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: turns per-cycle commit events (register write,
// load/store, halt) into ordered trace records, counts instructions,
// active cycles and dropped records, and offers the records on a
// valid/ready drain port.
// Optional feature: define TRACE_STAMP_EN to add rec_stamp, the active
// cycle count captured with each record.
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int REG_W  = 4,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       hlt,
    input  logic                       reg_we,
    input  logic [REG_W-1:0]           reg_idx,
    input  logic [DATA_W-1:0]          reg_data,
    input  logic                       mem_re,
    input  logic                       mem_we,
    input  logic [ADDR_W-1:0]          mem_addr,
    input  logic [DATA_W-1:0]          mem_rdata,
    input  logic [DATA_W-1:0]          mem_wdata,
    output logic                       rec_valid,
    input  logic                       rec_ready,
    output logic [1:0]                 rec_kind,
    output logic [REG_W-1:0]           rec_idx,
    output logic [ADDR_W-1:0]          rec_addr,
    output logic [DATA_W-1:0]          rec_data,
    output logic [CNT_W-1:0]           inst_count,
    output logic [CNT_W-1:0]           cycle_count,
    output logic [CNT_W-1:0]           drop_count,
    output logic [$clog2(DEPTH):0]     fill,
    output logic                       overflow,
    output logic                       halted
`ifdef TRACE_STAMP_EN
    ,
    output logic [CNT_W-1:0]           rec_stamp
`endif
);

`ifdef TRACE_STAMP_EN
    localparam int STAMP_W = CNT_W;
`else
    localparam int STAMP_W = 0;
`endif
    localparam int FILL_W = $clog2(DEPTH) + 1;
    localparam int REC_W  = 2 + REG_W + ADDR_W + DATA_W + STAMP_W;

    logic [CNT_W-1:0] r_inst_count;
    logic [CNT_W-1:0] r_cycle_count;
    logic [CNT_W-1:0] r_drop_count;
    logic             r_overflow;
    logic             r_halted;

    logic             w_active;
    logic             w_counted;
    logic             w_has_mem;
    logic [1:0]       w_pos_mem;
    logic [1:0]       w_pos_hlt;
    logic [1:0]       w_n_cand;
    logic [1:0]       w_push_cnt;
    logic [CNT_W-1:0] w_inst_next;
    logic             w_push_ok;
    logic [REC_W-1:0] w_head;
    logic [REC_W-1:0] w_push_data [MAX_PUSH];
    trace_rec_t       w_slot [MAX_PUSH];
    logic             w_unused_slot_bits;

    assign w_active    = en && !r_halted;
    assign w_counted   = reg_we || mem_we || hlt;
    assign w_has_mem   = mem_we || mem_re;
    assign w_inst_next = r_inst_count + CNT_W'(w_counted);

    // Slot positions keep the REG, memory, HALT order with no gaps.
    assign w_pos_mem  = {1'b0, reg_we};
    assign w_pos_hlt  = w_pos_mem + {1'b0, w_has_mem};
    assign w_n_cand   = w_pos_hlt + {1'b0, hlt};
    assign w_push_cnt = w_active ? w_n_cand : 2'd0;

    // Record formation: fill the candidate slots in fixed priority order.
    always_comb begin
        for (int k = 0; k < MAX_PUSH; k++) begin
            w_slot[k] = '0;
        end
        if (reg_we) begin
            w_slot[0] = rec_make(KIND_REG, MAX_IDX_W'(reg_idx), '0,
                                 MAX_DATA_W'(reg_data), MAX_STAMP_W'(r_cycle_count));
        end
        if (w_has_mem) begin
            // A store wins over a load when both strobes are set.
            w_slot[w_pos_mem] = rec_make(mem_we ? KIND_STORE : KIND_LOAD, '0,
                                         MAX_ADDR_W'(mem_addr),
                                         mem_we ? MAX_DATA_W'(mem_wdata) : MAX_DATA_W'(mem_rdata),
                                         MAX_STAMP_W'(r_cycle_count));
        end
        if (hlt) begin
            // HALT carries the instruction count including this cycle.
            w_slot[w_pos_hlt] = rec_make(KIND_HALT, '0, '0,
                                         MAX_DATA_W'(w_inst_next), MAX_STAMP_W'(r_cycle_count));
        end
    end

    // Narrow each slot to the configured field widths for storage.
    generate
        for (genvar gi = 0; gi < MAX_PUSH; gi++) begin : g_pack
            assign w_push_data[gi] = {
                w_slot[gi].kind,
                w_slot[gi].idx[REG_W-1:0],
                w_slot[gi].addr[ADDR_W-1:0],
                w_slot[gi].data[DATA_W-1:0]
`ifdef TRACE_STAMP_EN
                , w_slot[gi].stamp[CNT_W-1:0]
`endif
            };
        end
    endgenerate

    // Bits of the wide record struct beyond the configured widths.
    assign w_unused_slot_bits = ^{w_slot[0], w_slot[1], w_slot[2]};

    trace_fifo #(
        .REC_W (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push_cnt  (w_push_cnt),
        .i_push_data (w_push_data),
        .i_pop       (rec_ready),
        .o_push_ok   (w_push_ok),
        .o_head      (w_head),
        .o_valid     (rec_valid),
        .o_fill      (fill)
    );

    // Counters, drop accounting and halt latch; all frozen outside active cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst_count  <= '0;
            r_cycle_count <= '0;
            r_drop_count  <= '0;
            r_overflow    <= 1'b0;
            r_halted      <= 1'b0;
        end else if (w_active) begin
            r_cycle_count <= r_cycle_count + CNT_W'(1);
            if (w_counted) begin
                r_inst_count <= w_inst_next;
            end
            if (hlt) begin
                r_halted <= 1'b1;
            end
            if ((w_n_cand != 2'd0) && !w_push_ok) begin
                r_drop_count <= r_drop_count + CNT_W'(w_n_cand);
                r_overflow   <= 1'b1;
            end
        end
    end

    // Head record fields; the FIFO already zeroes the head when empty.
    assign rec_kind = w_head[REC_W-1 -: 2];
    assign rec_idx  = w_head[STAMP_W + DATA_W + ADDR_W +: REG_W];
    assign rec_addr = w_head[STAMP_W + DATA_W +: ADDR_W];
    assign rec_data = w_head[STAMP_W +: DATA_W];
`ifdef TRACE_STAMP_EN
    assign rec_stamp = w_head[CNT_W-1:0];
`endif

    assign inst_count  = r_inst_count;
    assign cycle_count = r_cycle_count;
    assign drop_count  = r_drop_count;
    assign overflow    = r_overflow;
    assign halted      = r_halted;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Testbench for commit_trace_buffer (DEPTH=4).
// Table-driven vectors followed by hand-written multi-cycle sequences.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_commit_trace_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, hlt, reg_we, mem_re, mem_we, rec_ready;
    logic [3:0]  reg_idx;
    logic [15:0] reg_data, mem_addr, mem_rdata, mem_wdata;
    logic        rec_valid, overflow, halted;
    logic [1:0]  rec_kind;
    logic [3:0]  rec_idx;
    logic [15:0] rec_addr, rec_data;
    logic [31:0] inst_count, cycle_count, drop_count;
    logic [2:0]  fill;
`ifdef TRACE_STAMP_EN
    logic [31:0] rec_stamp;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    commit_trace_buffer #(
        .DATA_W(16), .ADDR_W(16), .REG_W(4), .DEPTH(4), .CNT_W(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .hlt(hlt),
        .reg_we(reg_we), .reg_idx(reg_idx), .reg_data(reg_data),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_kind(rec_kind),
        .rec_idx(rec_idx), .rec_addr(rec_addr), .rec_data(rec_data),
        .inst_count(inst_count), .cycle_count(cycle_count),
        .drop_count(drop_count), .fill(fill), .overflow(overflow),
        .halted(halted)
`ifdef TRACE_STAMP_EN
        , .rec_stamp(rec_stamp)
`endif
    );

    typedef struct {
        logic        en, hlt, we;
        logic [3:0]  idx;
        logic [15:0] d;
        logic        re, mw;
        logic [15:0] a, rd, wd;
        logic        rdy;
        logic [2:0]  x_fill;
        logic [31:0] x_inst, x_cyc, x_drop;
        logic        x_ovf, x_halt;
        logic [1:0]  x_kind;
        logic [3:0]  x_idx;
        logic [15:0] x_addr, x_data;
    } vec_t;

    vec_t vt [11];

    function automatic vec_t mk(
        input logic en, input logic hlt, input logic we, input logic [3:0] idx,
        input logic [15:0] d, input logic re, input logic mw, input logic [15:0] a,
        input logic [15:0] rd, input logic [15:0] wd, input logic rdy,
        input logic [2:0] f, input logic [31:0] inst, input logic [31:0] cyc,
        input logic [31:0] drop, input logic ovf, input logic hl,
        input logic [1:0] k, input logic [3:0] xi, input logic [15:0] xa,
        input logic [15:0] xd);
        vec_t v;
        v.en = en; v.hlt = hlt; v.we = we; v.idx = idx; v.d = d;
        v.re = re; v.mw = mw; v.a = a; v.rd = rd; v.wd = wd; v.rdy = rdy;
        v.x_fill = f; v.x_inst = inst; v.x_cyc = cyc; v.x_drop = drop;
        v.x_ovf = ovf; v.x_halt = hl; v.x_kind = k; v.x_idx = xi;
        v.x_addr = xa; v.x_data = xd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        en = 1'b0; hlt = 1'b0; reg_we = 1'b0; reg_idx = '0; reg_data = '0;
        mem_re = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_rdata = '0;
        mem_wdata = '0; rec_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic chk_head(input string tag, input logic [1:0] k, input logic [3:0] i,
                            input logic [15:0] a, input logic [15:0] d);
        chk({tag, ".kind"}, 32'(rec_kind), 32'(k));
        chk({tag, ".idx"},  32'(rec_idx),  32'(i));
        chk({tag, ".addr"}, 32'(rec_addr), 32'(a));
        chk({tag, ".data"}, 32'(rec_data), 32'(d));
    endtask

    task automatic reg_push(input logic [3:0] idx, input logic [15:0] d);
        idle_inputs();
        en = 1'b1; reg_we = 1'b1; reg_idx = idx; reg_data = d;
    endtask

    initial begin
        // en hlt we idx d re mw a rd wd rdy | fill inst cyc drop ovf halt | kind idx addr data
        vt[0]  = mk(1'b1,1'b0,1'b1,4'd3,16'h00A5,1'b0,1'b0,16'h0,16'h0,16'h0,1'b0, 3'd1,32'd1,32'd1,32'd0,1'b0,1'b0, 2'd0,4'd3,16'h0,16'h00A5);
        vt[1]  = mk(1'b0,1'b0,1'b1,4'd5,16'h1234,1'b0,1'b0,16'h0,16'h0,16'h0,1'b0, 3'd1,32'd1,32'd1,32'd0,1'b0,1'b0, 2'd0,4'd3,16'h0,16'h00A5);
        vt[2]  = mk(1'b1,1'b0,1'b0,4'd0,16'h0,1'b1,1'b0,16'h0010,16'h5555,16'h0,1'b0, 3'd2,32'd1,32'd2,32'd0,1'b0,1'b0, 2'd0,4'd3,16'h0,16'h00A5);
        vt[3]  = mk(1'b1,1'b0,1'b0,4'd0,16'h0,1'b1,1'b1,16'h0020,16'h1111,16'hAAAA,1'b0, 3'd3,32'd2,32'd3,32'd0,1'b0,1'b0, 2'd0,4'd3,16'h0,16'h00A5);
        vt[4]  = mk(1'b1,1'b0,1'b1,4'd1,16'h0101,1'b1,1'b0,16'h0030,16'h7777,16'h0,1'b1, 3'd2,32'd3,32'd4,32'd2,1'b1,1'b0, 2'd1,4'd0,16'h0010,16'h5555);
        vt[5]  = mk(1'b0,1'b0,1'b0,4'd0,16'h0,1'b0,1'b0,16'h0,16'h0,16'h0,1'b1, 3'd1,32'd3,32'd4,32'd2,1'b1,1'b0, 2'd2,4'd0,16'h0020,16'hAAAA);
        vt[6]  = mk(1'b1,1'b0,1'b0,4'd0,16'h0,1'b0,1'b0,16'h0,16'h0,16'h0,1'b1, 3'd0,32'd3,32'd5,32'd2,1'b1,1'b0, 2'd0,4'd0,16'h0,16'h0);
        vt[7]  = mk(1'b1,1'b1,1'b1,4'd2,16'h2222,1'b0,1'b1,16'h0040,16'h0,16'hBEEF,1'b0, 3'd3,32'd4,32'd6,32'd2,1'b1,1'b1, 2'd0,4'd2,16'h0,16'h2222);
        vt[8]  = mk(1'b1,1'b0,1'b1,4'd7,16'h7777,1'b0,1'b0,16'h0,16'h0,16'h0,1'b1, 3'd2,32'd4,32'd6,32'd2,1'b1,1'b1, 2'd2,4'd0,16'h0040,16'hBEEF);
        vt[9]  = mk(1'b0,1'b0,1'b0,4'd0,16'h0,1'b0,1'b0,16'h0,16'h0,16'h0,1'b1, 3'd1,32'd4,32'd6,32'd2,1'b1,1'b1, 2'd3,4'd0,16'h0,16'h0004);
        vt[10] = mk(1'b0,1'b0,1'b0,4'd0,16'h0,1'b0,1'b0,16'h0,16'h0,16'h0,1'b1, 3'd0,32'd4,32'd6,32'd2,1'b1,1'b1, 2'd0,4'd0,16'h0,16'h0);

        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        do_reset();

        // Reset state
        chk("rst.fill", 32'(fill), 32'd0);
        chk("rst.valid", 32'(rec_valid), 32'd0);
        chk("rst.inst", inst_count, 32'd0);
        chk("rst.cyc", cycle_count, 32'd0);
        chk("rst.drop", drop_count, 32'd0);
        chk("rst.ovf", 32'(overflow), 32'd0);
        chk("rst.halt", 32'(halted), 32'd0);
        chk_head("rst", 2'd0, 4'd0, 16'h0, 16'h0);
        $display("reset: fill=%0d valid=%0d", fill, rec_valid);

        // Table-driven vectors
        for (int i = 0; i < 11; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            en = vt[i].en; hlt = vt[i].hlt; reg_we = vt[i].we; reg_idx = vt[i].idx;
            reg_data = vt[i].d; mem_re = vt[i].re; mem_we = vt[i].mw;
            mem_addr = vt[i].a; mem_rdata = vt[i].rd; mem_wdata = vt[i].wd;
            rec_ready = vt[i].rdy;
            tick();
            chk({t, ".fill"}, 32'(fill), 32'(vt[i].x_fill));
            chk({t, ".valid"}, 32'(rec_valid), 32'(vt[i].x_fill != 3'd0));
            chk({t, ".inst"}, inst_count, vt[i].x_inst);
            chk({t, ".cyc"}, cycle_count, vt[i].x_cyc);
            chk({t, ".drop"}, drop_count, vt[i].x_drop);
            chk({t, ".ovf"}, 32'(overflow), 32'(vt[i].x_ovf));
            chk({t, ".halt"}, 32'(halted), 32'(vt[i].x_halt));
            chk_head(t, vt[i].x_kind, vt[i].x_idx, vt[i].x_addr, vt[i].x_data);
            $display("%s: fill=%0d inst=%0d cyc=%0d drop=%0d head=%0d/%0h/%0h/%0h",
                     t, fill, inst_count, cycle_count, drop_count, rec_kind, rec_idx, rec_addr, rec_data);
        end

        // Triple record in one cycle, then halt freezes capture while draining
        do_reset();
        reg_push(4'd1, 16'h1111);
        mem_we = 1'b1; mem_addr = 16'h0040; mem_wdata = 16'hBEEF; hlt = 1'b1;
        tick();
        chk("tri.fill", 32'(fill), 32'd3);
        chk("tri.halt", 32'(halted), 32'd1);
        chk("tri.inst", inst_count, 32'd1);
        reg_push(4'd9, 16'h9999);
        rec_ready = 1'b1;
        chk_head("tri.r0", 2'd0, 4'd1, 16'h0, 16'h1111);
        tick();
        chk_head("tri.r1", 2'd2, 4'd0, 16'h0040, 16'hBEEF);
        tick();
        chk_head("tri.r2", 2'd3, 4'd0, 16'h0, 16'h0001);
        tick();
        chk("tri.empty", 32'(fill), 32'd0);
        chk("tri.inst_frozen", inst_count, 32'd1);
        chk("tri.cyc_frozen", cycle_count, 32'd1);
        $display("triple+halt: fill=%0d halted=%0d inst=%0d", fill, halted, inst_count);

        // Overflow with a full buffer, then a push against a same-cycle pop
        do_reset();
        for (int i = 0; i < 4; i++) begin
            reg_push(4'(i), 16'h0010 + 16'(i));
            tick();
        end
        reg_push(4'd4, 16'h0014);
        mem_re = 1'b1; mem_addr = 16'h0050;
        tick();
        chk("ovf.fill", 32'(fill), 32'd4);
        chk("ovf.drop", drop_count, 32'd2);
        chk("ovf.flag", 32'(overflow), 32'd1);
        chk("ovf.inst", inst_count, 32'd5);
        reg_push(4'd5, 16'h0015);
        rec_ready = 1'b1;
        tick();
        chk("full_pop.fill", 32'(fill), 32'd3);
        chk("full_pop.drop", drop_count, 32'd3);
        chk_head("full_pop", 2'd0, 4'd1, 16'h0, 16'h0011);
        $display("overflow: fill=%0d drop=%0d inst=%0d", fill, drop_count, inst_count);

        // Streaming through pointer wrap
        do_reset();
        for (int i = 0; i < 37; i++) begin
            reg_push(4'(i), 16'h0100 + 16'(i));
            rec_ready = 1'b1;
            tick();
            chk($sformatf("wrap%0d.fill", i), 32'(fill), 32'd1);
            chk($sformatf("wrap%0d.data", i), 32'(rec_data), 32'h0100 + 32'(i));
        end
        idle_inputs();
        rec_ready = 1'b1;
        tick();
        chk("wrap.empty", 32'(fill), 32'd0);
        chk("wrap.cyc", cycle_count, 32'd37);
        $display("wrap: 37 records streamed, cyc=%0d", cycle_count);

        // Asynchronous reset discards buffered records at once
        do_reset();
        reg_push(4'd1, 16'h00AA);
        mem_re = 1'b1; mem_addr = 16'h0060; mem_rdata = 16'h00BB;
        tick();
        reg_push(4'd2, 16'h00CC);
        tick();
        idle_inputs();
        chk("arst.pre_fill", 32'(fill), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.fill", 32'(fill), 32'd0);
        chk("arst.valid", 32'(rec_valid), 32'd0);
        chk("arst.data", 32'(rec_data), 32'd0);
        chk("arst.inst", inst_count, 32'd0);
        $display("async reset: fill=%0d valid=%0d", fill, rec_valid);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef TRACE_STAMP_EN
        // Stamp counts only active cycles
        do_reset();
        repeat (5) tick();
        en = 1'b1;
        repeat (2) tick();
        reg_push(4'd3, 16'h0033);
        tick();
        idle_inputs();
        chk("stamp.value", rec_stamp, 32'd2);
        chk("stamp.cyc", cycle_count, 32'd3);
        $display("stamp: rec_stamp=%0d cyc=%0d", rec_stamp, cycle_count);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
